q_frame_sink: RTL and testbench

Q_FRAME_SINK -- requirements
Module: q_frame_sink

---
 rtl/q_frame_sink.sv | 156 +++++++++++++++
 tb/tb_q_frame_sink.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/q_frame_sink.sv
// q_frame_sink: ping-pong frame buffer for a quantized pixel stream. Checks line and
// frame framing on the way in and publishes each complete, well-formed frame to a reader.
module q_frame_sink #(
    parameter int W          = 32,
    parameter int H          = 32,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 10
) (
    input  logic                         clk_in_100,
    input  logic                         arst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_pixel,
    input  logic                         in_line_last,
    input  logic                         in_frame_last,
    input  logic        [ADDR_W-1:0]     rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         frame_ready,
    input  logic                         frame_ack,
    output logic                         rd_bank,
    output logic                         err_line,
    output logic                         err_frame,
    output logic        [15:0]           frame_cnt,
    output logic        [7:0]            drop_cnt
);
    localparam int NPIX  = W * H;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam int MEM_W = $clog2(2 * NPIX);
    localparam logic [ADDR_W:0]    NPIX_A   = (ADDR_W + 1)'(NPIX);
    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(W - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(H - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Bank b occupies words b*NPIX .. b*NPIX+NPIX-1
    logic signed [DATA_WIDTH-1:0] mem_q [0:2*NPIX-1];

    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic                         bad_q, bad_d;
    logic                         wr_bank_q, wr_bank_d;
    logic                         rd_bank_q, rd_bank_d;
    logic                         ready_q, ready_d;
    logic                         err_line_q, err_line_d;
    logic                         err_frame_q, err_frame_d;
    logic [15:0]                  frame_cnt_q, frame_cnt_d;
    logic [7:0]                   drop_cnt_q, drop_cnt_d;
    logic signed [DATA_WIDTH-1:0] rd_data_q;

    logic             at_eol;
    logic             at_eof;
    logic             line_err;
    logic             rd_in_range;
    logic [MEM_W-1:0] wr_idx;
    logic [MEM_W-1:0] rd_idx;

    assign at_eol      = (col_q == COL_LAST);
    assign at_eof      = at_eol && (row_q == ROW_LAST);
    assign line_err    = (in_line_last != at_eol);
    assign rd_in_range = ({1'b0, rd_addr} < NPIX_A);
    assign wr_idx      = MEM_W'(wr_bank_q) * MEM_W'(NPIX) + MEM_W'(row_q) * MEM_W'(W) + MEM_W'(col_q);
    assign rd_idx      = MEM_W'(rd_bank_q) * MEM_W'(NPIX) + MEM_W'(rd_addr);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        bad_d       = bad_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        ready_d     = ready_q;
        err_line_d  = err_line_q;
        err_frame_d = err_frame_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (frame_ack && ready_q) begin
            ready_d = 1'b0;
        end

        if (in_valid) begin
            if (line_err) begin
                err_line_d = 1'b1;
                bad_d      = 1'b1;
            end
            if (at_eof || in_frame_last) begin
                // Any frame boundary, good or bad, realigns the write position.
                col_d = '0;
                row_d = '0;
                bad_d = 1'b0;
                if (at_eof != in_frame_last) begin
                    err_frame_d = 1'b1;
                end else if (!line_err && !bad_q) begin
                    if (!ready_q || frame_ack) begin
                        rd_bank_d   = wr_bank_q;
                        wr_bank_d   = ~wr_bank_q;
                        ready_d     = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        drop_cnt_d = sat_inc8(drop_cnt_q);
                    end
                end
            end else if (at_eol || in_line_last) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in_100 or negedge arst_n) begin
        if (!arst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            bad_q       <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b1;
            ready_q     <= 1'b0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            bad_q       <= bad_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            ready_q     <= ready_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            rd_data_q   <= rd_in_range ? mem_q[rd_idx] : '0;
        end
    end

    // Writes always target wr_bank, which is never the published bank.
    always_ff @(posedge clk_in_100) begin
        if (in_valid) begin
            mem_q[wr_idx] <= in_pixel;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_ready = ready_q;
    assign rd_bank     = rd_bank_q;
    assign err_line    = err_line_q;
    assign err_frame   = err_frame_q;
    assign frame_cnt   = frame_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_q_frame_sink.sv
// Directed bench for q_frame_sink: frame-level vector table plus hand sequences
// for simultaneous publish/ack and asynchronous reset in mid-frame.
module tb_q_frame_sink;
    localparam int W    = 32;
    localparam int H    = 32;
    localparam int NPIX = W * H;
    localparam int AW   = 11;

    localparam int K_RAMP  = 0;
    localparam int K_CONST = 1;
    localparam int K_LINE  = 2;
    localparam int K_EARLY = 3;
    localparam int K_NOEND = 4;
    localparam int K_NONE  = -1;

    logic                clk = 1'b0;
    logic                arst_n;
    logic                in_valid;
    logic signed [7:0]   in_pixel;
    logic                in_line_last;
    logic                in_frame_last;
    logic [AW-1:0]       rd_addr;
    logic signed [7:0]   rd_data;
    logic                frame_ready;
    logic                frame_ack;
    logic                rd_bank;
    logic                err_line;
    logic                err_frame;
    logic [15:0]         frame_cnt;
    logic [7:0]          drop_cnt;

    int tests = 0;
    int fails = 0;

    q_frame_sink #(.W(W), .H(H), .DATA_WIDTH(8), .ADDR_W(AW)) dut (
        .clk_in_100   (clk),
        .arst_n       (arst_n),
        .in_valid     (in_valid),
        .in_pixel     (in_pixel),
        .in_line_last (in_line_last),
        .in_frame_last(in_frame_last),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_ready  (frame_ready),
        .frame_ack    (frame_ack),
        .rd_bank      (rd_bank),
        .err_line     (err_line),
        .err_frame    (err_frame),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int param;
        bit ack_before;
        bit exp_ready;
        bit exp_bank;
        int exp_fcnt;
        int exp_dcnt;
        bit exp_el;
        bit exp_ef;
        int chk_kind;
        int chk_val;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_pix(input int kind, input int val, input int a);
        if (kind == K_RAMP) return (a % 256) - 128;
        return val;
    endfunction

    task automatic check_state(input string tag, input bit r, input bit b, input int f,
                               input int d, input bit el, input bit ef);
        chk({tag, " frame_ready"}, int'(frame_ready), int'(r));
        chk({tag, " rd_bank"},     int'(rd_bank),     int'(b));
        chk({tag, " frame_cnt"},   int'(frame_cnt),   f);
        chk({tag, " drop_cnt"},    int'(drop_cnt),    d);
        chk({tag, " err_line"},    int'(err_line),    int'(el));
        chk({tag, " err_frame"},   int'(err_frame),   int'(ef));
    endtask

    task automatic check_bank(input string tag, input int kind, input int val);
        int bad = 0;
        for (int a = 0; a < NPIX; a++) begin
            rd_addr = AW'(a);
            step();
            if (int'(rd_data) != exp_pix(kind, val, a)) bad++;
        end
        chk({tag, " readback mismatching words"}, bad, 0);
    endtask

    task automatic send_frame(input int kind, input int val, input bit ack_last, input int max_beats);
        int sent = 0;
        for (int i = 0; i < NPIX; i++) begin
            int r;
            int c;
            bit ll;
            bit fl;
            r = i / W;
            c = i % W;
            if (sent >= max_beats) break;
            if (kind == K_EARLY && i >= 512) break;
            if (kind == K_LINE && r == 3 && c > val) continue;
            ll = (c == W - 1) || (kind == K_LINE && r == 3 && c == val);
            fl = ((kind == K_RAMP || kind == K_CONST || kind == K_LINE) && i == NPIX - 1)
                 || (kind == K_EARLY && i == 511);
            in_valid      = 1'b1;
            in_pixel      = 8'(exp_pix(kind, val, i));
            in_line_last  = ll;
            in_frame_last = fl;
            frame_ack     = ack_last && (i == NPIX - 1);
            step();
            sent++;
        end
        in_valid      = 1'b0;
        in_line_last  = 1'b0;
        in_frame_last = 1'b0;
        frame_ack     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{K_RAMP,    0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, K_RAMP,  0};
        vecs[1] = '{K_CONST,  -5, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0, K_CONST, -5};
        vecs[2] = '{K_CONST,   7, 1'b0, 1'b1, 1'b1, 2, 1, 1'b0, 1'b0, K_CONST, -5};
        vecs[3] = '{K_LINE,   20, 1'b1, 1'b0, 1'b1, 2, 1, 1'b1, 1'b0, K_NONE,  0};
        vecs[4] = '{K_RAMP,    0, 1'b0, 1'b1, 1'b0, 3, 1, 1'b1, 1'b0, K_RAMP,  0};
        vecs[5] = '{K_EARLY,   3, 1'b1, 1'b0, 1'b0, 3, 1, 1'b1, 1'b1, K_NONE,  0};
        vecs[6] = '{K_CONST, -128, 1'b0, 1'b1, 1'b1, 4, 1, 1'b1, 1'b1, K_CONST, -128};
        vecs[7] = '{K_CONST, 127, 1'b1, 1'b1, 1'b0, 5, 1, 1'b1, 1'b1, K_CONST, 127};

        arst_n        = 1'b1;
        in_valid      = 1'b0;
        in_pixel      = '0;
        in_line_last  = 1'b0;
        in_frame_last = 1'b0;
        frame_ack     = 1'b0;
        rd_addr       = '0;

        #2 arst_n = 1'b0;
        #1;
        check_state("reset", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        chk("reset rd_data", int'(rd_data), 0);
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].ack_before) begin
                frame_ack = 1'b1;
                step();
                frame_ack = 1'b0;
            end
            send_frame(vecs[v].kind, vecs[v].param, 1'b0, NPIX);
            check_state($sformatf("vec%0d", v), vecs[v].exp_ready, vecs[v].exp_bank,
                        vecs[v].exp_fcnt, vecs[v].exp_dcnt, vecs[v].exp_el, vecs[v].exp_ef);
            if (vecs[v].chk_kind != K_NONE)
                check_bank($sformatf("vec%0d", v), vecs[v].chk_kind, vecs[v].chk_val);
            if (v == 0) begin
                rd_addr = AW'(NPIX);
                step();
                chk("read addr 1024", int'(rd_data), 0);
                rd_addr = AW'(2047);
                step();
                chk("read addr 2047", int'(rd_data), 0);
                rd_addr = AW'(NPIX - 1);
                step();
                chk("read addr 1023", int'(rd_data), 127);
            end
        end

        // Good frame end coincides with ack while a frame is already published
        send_frame(K_RAMP, 0, 1'b1, NPIX);
        check_state("simul ack", 1'b1, 1'b1, 6, 1, 1'b1, 1'b1);
        check_bank("simul ack", K_RAMP, 0);

        // Asynchronous reset after 300 beats of a frame
        send_frame(K_CONST, 33, 1'b0, 300);
        #2 arst_n = 1'b0;
        #1;
        check_state("mid reset", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        chk("mid reset rd_data", int'(rd_data), 0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        step();

        send_frame(K_RAMP, 0, 1'b0, NPIX);
        check_state("after reset", 1'b1, 1'b0, 1, 0, 1'b0, 1'b0);
        check_bank("after reset", K_RAMP, 0);

        send_frame(K_CONST, 9, 1'b0, NPIX);
        check_state("drop", 1'b1, 1'b0, 1, 1, 1'b0, 1'b0);
        check_bank("drop", K_RAMP, 0);

        send_frame(K_NOEND, 4, 1'b0, NPIX);
        check_state("no end", 1'b1, 1'b0, 1, 1, 1'b0, 1'b1);

        send_frame(K_RAMP, 0, 1'b0, NPIX);
        check_state("realign", 1'b1, 1'b0, 1, 2, 1'b0, 1'b1);
        check_bank("realign", K_RAMP, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
